// File: rtl/frame_writer_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the frame_writer pixel-to-framebuffer block.
package frame_writer_pkg;

    localparam int unsigned DIM_W = 8;
    localparam int unsigned RGB_W = 24;
    localparam int unsigned CRC_W = 16;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } rgb_t;

    localparam logic [CRC_W-1:0] CRC_POLY = 16'h1021;
    localparam logic [CRC_W-1:0] CRC_INIT = 16'hFFFF;

    // One MSB-first CRC-16-CCITT byte update.
    function automatic logic [CRC_W-1:0] crc16_byte(input logic [CRC_W-1:0] crc,
                                                    input logic [7:0]       data);
        logic [CRC_W-1:0] c;
        c = crc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            c = c[CRC_W-1] ? ((c << 1) ^ CRC_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/frame_writer_crc16.sv
`timescale 1ns/1ps
// Combinational CRC-16-CCITT update over one pixel, bytes taken R, G, B in order.
module frame_writer_crc16
    import frame_writer_pkg::*;
(
    input  logic [CRC_W-1:0] crc,
    input  rgb_t             pixel,
    output logic [CRC_W-1:0] crc_next_c
);

    always_comb begin
        crc_next_c = crc16_byte(crc16_byte(crc16_byte(crc, pixel.red), pixel.green), pixel.blue);
    end

endmodule

// File: rtl/frame_writer.sv
`timescale 1ns/1ps
// Pixel stream sink: checks framing against latched dimensions and issues linear framebuffer writes.
// Define FRAME_WRITER_CRC_EN to add the per-frame CRC-16 output frame_crc.
module frame_writer
    import frame_writer_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIM_W-1:0]     image_width,
    input  logic [DIM_W-1:0]     image_height,
    input  logic                 validRead,
    output logic                 ReadyExternal,
    input  logic                 Sof,
    input  logic                 lastX,
    input  logic [7:0]           red,
    input  logic [7:0]           green,
    input  logic [7:0]           blue,
    output logic                 wr_valid,
    input  logic                 wr_ready,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [RGB_W-1:0]     wr_data,
    output logic                 frame_done,
    output logic                 busy,
    input  logic                 clear_err,
    output logic                 error,
`ifdef FRAME_WRITER_CRC_EN
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [CRC_W-1:0]     frame_crc
`else
    output logic [ERR_CNT_W-1:0] err_count
`endif
);

    state_t             state_q, state_d;
    logic [DIM_W-1:0]   x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
    logic [DIM_W-1:0]   cx, cy, cw, ch;
    logic [ADDR_W-1:0]  addr_q, addr_d, base_q, base_d, ca, cb, write_addr_c;
    logic               drop_q, drop_d;
    logic               accept_c, sof_ok_c, write_c, last_c, err_evt_c;
    logic               x_end_c, line_end_c, frame_end_c;
    logic               wr_last;
    rgb_t               pix_c;

    assign ReadyExternal = !wr_valid || wr_ready;
    assign accept_c      = validRead && ReadyExternal;
    assign sof_ok_c      = accept_c && Sof && (image_width != '0) && (image_height != '0);
    assign pix_c         = {red, green, blue};
    assign busy          = (state_q == ACTIVE);

    // Next-state, position tracking and error detection for one accepted pixel.
    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        w_d          = w_q;
        h_d          = h_q;
        addr_d       = addr_q;
        base_d       = base_q;
        drop_d       = drop_q;
        write_c      = 1'b0;
        last_c       = 1'b0;
        err_evt_c    = 1'b0;
        write_addr_c = '0;
        cx           = '0;
        cy           = '0;
        cw           = w_q;
        ch           = h_q;
        ca           = '0;
        cb           = '0;
        x_end_c      = 1'b0;
        line_end_c   = 1'b0;
        frame_end_c  = 1'b0;

        if (accept_c) begin
            if (Sof) begin
                drop_d = 1'b0;
                if (sof_ok_c) begin
                    // Restart from origin with freshly latched dimensions.
                    write_c   = 1'b1;
                    cw        = image_width;
                    ch        = image_height;
                    w_d       = image_width;
                    h_d       = image_height;
                    err_evt_c = (state_q == ACTIVE);
                end else begin
                    err_evt_c = 1'b1;
                    state_d   = IDLE;
                end
            end else if (state_q == ACTIVE) begin
                write_c = 1'b1;
                cx      = x_q;
                cy      = y_q;
                ca      = addr_q;
                cb      = base_q;
            end else begin
                // Only the first pixel of a contiguous drop run raises an error.
                drop_d    = 1'b1;
                err_evt_c = !drop_q;
            end

            if (write_c) begin
                drop_d       = 1'b0;
                write_addr_c = ca;
                x_end_c      = (cx == cw - DIM_W'(1));
                line_end_c   = x_end_c || lastX;
                frame_end_c  = line_end_c && (cy == ch - DIM_W'(1));
                if (x_end_c != lastX) begin
                    err_evt_c = 1'b1;
                end
                if (frame_end_c) begin
                    state_d = IDLE;
                    last_c  = 1'b1;
                    x_d     = '0;
                    y_d     = '0;
                    addr_d  = '0;
                    base_d  = '0;
                end else if (line_end_c) begin
                    state_d = ACTIVE;
                    x_d     = '0;
                    y_d     = cy + DIM_W'(1);
                    base_d  = cb + ADDR_W'(cw);
                    addr_d  = cb + ADDR_W'(cw);
                end else begin
                    state_d = ACTIVE;
                    x_d     = cx + DIM_W'(1);
                    y_d     = cy;
                    base_d  = cb;
                    addr_d  = ca + ADDR_W'(1);
                end
            end
        end
    end

    // State and position registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            w_q     <= '0;
            h_q     <= '0;
            addr_q  <= '0;
            base_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            w_q     <= w_d;
            h_q     <= h_d;
            addr_q  <= addr_d;
            base_q  <= base_d;
            drop_q  <= drop_d;
        end
    end

    // Single-entry write output stage; held while the framebuffer stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_valid   <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            wr_last    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            if (write_c) begin
                wr_valid <= 1'b1;
                wr_addr  <= write_addr_c;
                wr_data  <= pix_c;
                wr_last  <= last_c;
            end else if (wr_ready) begin
                wr_valid <= 1'b0;
            end
            frame_done <= wr_valid && wr_ready && wr_last;
        end
    end

    // Sticky error flag and saturating counter; a same-cycle event beats clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            error     <= 1'b0;
            err_count <= '0;
        end else if (err_evt_c) begin
            error <= 1'b1;
            if (clear_err) begin
                err_count <= ERR_CNT_W'(1);
            end else if (err_count != '1) begin
                err_count <= err_count + ERR_CNT_W'(1);
            end
        end else if (clear_err) begin
            error     <= 1'b0;
            err_count <= '0;
        end
    end

`ifdef FRAME_WRITER_CRC_EN
    logic [CRC_W-1:0] crc_q, crc_seed_c, crc_next_c;

    assign crc_seed_c = sof_ok_c ? CRC_INIT : crc_q;

    frame_writer_crc16 u_crc16 (
        .crc        (crc_seed_c),
        .pixel      (pix_c),
        .crc_next_c (crc_next_c)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            crc_q <= CRC_INIT;
        end else if (write_c) begin
            crc_q <= crc_next_c;
        end
    end

    assign frame_crc = crc_q;
`endif

endmodule

// File: tb/tb_frame_writer.sv
`timescale 1ns/1ps
// Directed scoreboard bench for frame_writer; covers framing errors, stalls, restart and reset abort.
module tb_frame_writer;

    localparam int unsigned ADDR_W    = 16;
    localparam int unsigned ERR_CNT_W = 8;

    logic                 clk;
    logic                 reset;
    logic [7:0]           image_width;
    logic [7:0]           image_height;
    logic                 validRead;
    logic                 ReadyExternal;
    logic                 Sof;
    logic                 lastX;
    logic [7:0]           red;
    logic [7:0]           green;
    logic [7:0]           blue;
    logic                 wr_valid;
    logic                 wr_ready;
    logic [ADDR_W-1:0]    wr_addr;
    logic [23:0]          wr_data;
    logic                 frame_done;
    logic                 busy;
    logic                 clear_err;
    logic                 error;
    logic [ERR_CNT_W-1:0] err_count;
`ifdef FRAME_WRITER_CRC_EN
    logic [15:0]          frame_crc;
    logic [15:0]          crc_model;
`endif

    frame_writer #(.ADDR_W(ADDR_W), .ERR_CNT_W(ERR_CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .image_width   (image_width),
        .image_height  (image_height),
        .validRead     (validRead),
        .ReadyExternal (ReadyExternal),
        .Sof           (Sof),
        .lastX         (lastX),
        .red           (red),
        .green         (green),
        .blue          (blue),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .frame_done    (frame_done),
        .busy          (busy),
        .clear_err     (clear_err),
        .error         (error),
`ifdef FRAME_WRITER_CRC_EN
        .err_count     (err_count),
        .frame_crc     (frame_crc)
`else
        .err_count     (err_count)
`endif
    );

    typedef struct {
        int unsigned addr;
        logic [23:0] data;
        bit          last;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          errors = 0;
    int          checks = 0;
    int unsigned done_cnt = 0;
    int unsigned exp_frames = 0;
    int          mode = 0;
    int          pidx = 0;
    logic [3:0]  pat = 4'b1001;
    logic [7:0]  pix_seq = 8'h10;
    logic        exp_done = 1'b0;
    bit          prev_stall = 1'b0;
    logic [15:0] prev_addr;
    logic [23:0] prev_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

`ifdef FRAME_WRITER_CRC_EN
    function automatic logic [15:0] ref_crc_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ b[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction
`endif

    // Framebuffer ready pattern: 0 always ready, 1 cycles 1,0,0,1, 2 never ready.
    initial begin
        wr_ready = 1'b1;
        forever begin
            @(negedge clk);
            #2;
            case (mode)
                0:       wr_ready = 1'b1;
                1: begin
                    wr_ready = pat[pidx];
                    pidx     = (pidx + 1) % 4;
                end
                default: wr_ready = 1'b0;
            endcase
        end
    end

    // Write monitor: pops the scoreboard on each handshake and checks stall stability and frame_done timing.
    always @(negedge clk) begin
        #3;
        if (!reset) begin
            exp_done   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            chk("frame_done", frame_done, exp_done);
            if (frame_done) done_cnt++;
            if (prev_stall) begin
                chk("stall_valid", wr_valid, 1);
                chk("stall_addr", wr_addr, prev_addr);
                chk("stall_data", wr_data, prev_data);
            end
            if (wr_valid && !wr_ready) chk("ready_stalled", ReadyExternal, 0);
            if (!wr_valid) chk("ready_idle", ReadyExternal, 1);
            exp_done = 1'b0;
            if (wr_valid && wr_ready) begin
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL spurious_write: observed addr 0x%0h data 0x%0h expected no write",
                           wr_addr, wr_data);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("wr_addr", wr_addr, e.addr);
                    chk("wr_data", wr_data, e.data);
                    exp_done = e.last;
                end
            end
            prev_stall = wr_valid && !wr_ready;
            prev_addr  = wr_addr;
            prev_data  = wr_data;
        end
    end

    // Entered and left at negedge+1; the handshake sample is taken at negedge+3.
    task automatic send(input bit sof, input bit lx, input bit wr, input int unsigned addr, input bit last);
        logic [23:0] d;
        bit          rdy;
        int          n;
        d       = {pix_seq, pix_seq ^ 8'h5A, pix_seq + 8'd3};
        pix_seq = pix_seq + 8'd1;
        validRead = 1'b1;
        Sof       = sof;
        lastX     = lx;
        {red, green, blue} = d;
        rdy = 1'b0;
        n   = 0;
        while (!rdy && n < 100) begin
            #2;
            rdy = ReadyExternal;
            if (rdy && wr) begin
                sb.push_back('{addr: addr, data: d, last: last});
`ifdef FRAME_WRITER_CRC_EN
                if (sof) crc_model = 16'hFFFF;
                crc_model = ref_crc_byte(ref_crc_byte(ref_crc_byte(crc_model, d[23:16]), d[15:8]), d[7:0]);
`endif
            end
            @(posedge clk);
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        assert (rdy) else begin
            errors++;
            $error("FAIL accept_timeout: observed no acceptance expected acceptance within 100 cycles");
        end
        validRead = 1'b0;
        Sof       = 1'b0;
        lastX     = 1'b0;
    endtask

    task automatic frame(input int w, input int h);
        image_width  = 8'(w);
        image_height = 8'(h);
        for (int yy = 0; yy < h; yy++) begin
            for (int xx = 0; xx < w; xx++) begin
                send(xx == 0 && yy == 0, xx == w - 1, 1'b1, int'(yy * w + xx), xx == w - 1 && yy == h - 1);
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || wr_valid) && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        repeat (2) @(negedge clk);
        #1;
        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL drain: observed %0d writes outstanding expected 0", sb.size());
        end
    endtask

    task automatic do_clear();
        clear_err = 1'b1;
        @(negedge clk);
        #1;
        clear_err = 1'b0;
        chk("clear_error", error, 0);
        chk("clear_count", err_count, 0);
    endtask

    task automatic frame_checks(input string tag, input int unsigned exp_err);
        chk({tag, "_err_count"}, err_count, exp_err);
        chk({tag, "_error"}, error, exp_err != 0);
        chk({tag, "_frames"}, done_cnt, exp_frames);
        chk({tag, "_busy"}, busy, 0);
`ifdef FRAME_WRITER_CRC_EN
        chk({tag, "_crc"}, frame_crc, crc_model);
`endif
    endtask

    initial begin
        reset        = 1'b0;
        validRead    = 1'b0;
        Sof          = 1'b0;
        lastX        = 1'b0;
        red          = 8'h00;
        green        = 8'h00;
        blue         = 8'h00;
        image_width  = 8'd4;
        image_height = 8'd2;
        clear_err    = 1'b0;
`ifdef FRAME_WRITER_CRC_EN
        crc_model    = 16'hFFFF;
`endif
        repeat (3) @(negedge clk);
        #1;
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_ready", ReadyExternal, 1);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_error", error, 0);
        chk("rst_err_count", err_count, 0);
`ifdef FRAME_WRITER_CRC_EN
        chk("rst_crc", frame_crc, 16'hFFFF);
`endif
        reset = 1'b1;
        @(negedge clk);
        #1;

        // 4x2 frame, framebuffer always ready.
        mode = 0;
        frame(4, 2);
        exp_frames++;
        drain();
        frame_checks("t1", 0);

        // Same frame with a stalling framebuffer.
        mode = 1;
        frame(4, 2);
        exp_frames++;
        drain();
        mode = 0;
        frame_checks("t2", 0);

        // Three orphan pixels are dropped as one error, then a 2x1 frame.
        send(1'b0, 1'b0, 1'b0, 0, 1'b0);
        send(1'b0, 1'b0, 1'b0, 0, 1'b0);
        send(1'b0, 1'b1, 1'b0, 0, 1'b0);
        frame(2, 1);
        exp_frames++;
        drain();
        frame_checks("t3", 1);
        do_clear();

        // Early lastX on x=2 of line 0 forces the next pixel to x=0, y=1.
        image_width  = 8'd4;
        image_height = 8'd2;
        send(1'b1, 1'b0, 1'b1, 0, 1'b0);
        chk("t4_busy_active", busy, 1);
        send(1'b0, 1'b0, 1'b1, 1, 1'b0);
        send(1'b0, 1'b1, 1'b1, 2, 1'b0);
        send(1'b0, 1'b0, 1'b1, 4, 1'b0);
        send(1'b0, 1'b0, 1'b1, 5, 1'b0);
        send(1'b0, 1'b0, 1'b1, 6, 1'b0);
        send(1'b0, 1'b1, 1'b1, 7, 1'b1);
        exp_frames++;
        drain();
        frame_checks("t4", 1);
        do_clear();

        // Sof on the 5th pixel restarts the frame at address 0.
        send(1'b1, 1'b0, 1'b1, 0, 1'b0);
        send(1'b0, 1'b0, 1'b1, 1, 1'b0);
        send(1'b0, 1'b0, 1'b1, 2, 1'b0);
        send(1'b0, 1'b1, 1'b1, 3, 1'b0);
        frame(4, 2);
        exp_frames++;
        drain();
        frame_checks("t5", 1);
        do_clear();

        // Reset mid-frame with a write held by the framebuffer.
        send(1'b1, 1'b0, 1'b1, 0, 1'b0);
        send(1'b0, 1'b0, 1'b1, 1, 1'b0);
        send(1'b0, 1'b0, 1'b1, 2, 1'b0);
        mode = 2;
        @(negedge clk);
        #1;
        chk("t6_held_valid", wr_valid, 1);
        reset = 1'b0;
        sb.delete();
        #1;
        chk("t6_rst_wr_valid", wr_valid, 0);
        chk("t6_rst_ready", ReadyExternal, 1);
        chk("t6_rst_busy", busy, 0);
        @(negedge clk);
        #1;
        mode  = 0;
        reset = 1'b1;
        @(negedge clk);
        #1;
        frame(4, 2);
        exp_frames++;
        drain();
        frame_checks("t6", 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
